// File: rtl/id_stage_regfile_pipe.sv
// Purpose : MIPS ID stage - register file, field decode, immediate extension and ID/EX output bank.
// Latency : one clock from instruction/pc_in to the ID/EX outputs; register reads are combinational.
// Backpr. : stall holds the output bank, flush inserts a bubble; hazard_stall is a request only.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid, instruction, pc_in       instruction arriving from IF/ID
//   stall, flush                       output bank control (flush wins over stall)
//   reg_write, write_addr, write_data  write-back port
//   ex_mem_read, ex_rt_addr            load in EX, used for load-use detection
//   hazard_stall                       combinational load-use stall request
//   out_valid, rs_data, rt_data, rs/rt/rd_addr_out, opcode, funct, extended_imm, pc_out
//                                      registered ID/EX bank
//
// Optional macro WB_BYPASS_EN: a write-back to the register being read is forwarded
// to the read port in the same cycle instead of appearing one cycle later.
module id_stage_regfile_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              reg_write,
    input  logic [4:0]        write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt_addr,
    output logic              hazard_stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [4:0]        rs_addr_out,
    output logic [4:0]        rt_addr_out,
    output logic [4:0]        rd_addr_out,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] extended_imm,
    output logic [DATA_W-1:0] pc_out
);

    localparam int         AW      = $clog2(REG_CNT);
    localparam logic [5:0] REG_LIM = 6'(REG_CNT);

    logic [DATA_W-1:0] regs [REG_CNT];

    logic [4:0]        rs_f;
    logic [4:0]        rt_f;
    logic [4:0]        rd_f;
    logic [5:0]        op_f;
    logic [5:0]        fn_f;
    logic [15:0]       imm_f;
    logic              wr_en;
    logic [DATA_W-1:0] rs_rd;
    logic [DATA_W-1:0] rt_rd;
    logic [DATA_W-1:0] ext_imm;

    assign op_f  = instruction[31:26];
    assign rs_f  = instruction[25:21];
    assign rt_f  = instruction[20:16];
    assign rd_f  = instruction[15:11];
    assign fn_f  = instruction[5:0];
    assign imm_f = instruction[15:0];

    // An index is backed by real storage only when it is in range and is not
    // the hard-wired zero register. The same test gates reads, writes and bypass.
    function automatic logic idx_live(input logic [4:0] idx);
        return ({1'b0, idx} < REG_LIM) && !((R0_ZERO != 0) && (idx == 5'd0));
    endfunction

    assign wr_en = reg_write && idx_live(write_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[write_addr[AW-1:0]] <= write_data;
        end
    end

    always_comb begin
        rs_rd = '0;
        rt_rd = '0;
        if (idx_live(rs_f)) begin
            rs_rd = regs[rs_f[AW-1:0]];
`ifdef WB_BYPASS_EN
            if (wr_en && (write_addr == rs_f)) begin
                rs_rd = write_data;
            end
`endif
        end
        if (idx_live(rt_f)) begin
            rt_rd = regs[rt_f[AW-1:0]];
`ifdef WB_BYPASS_EN
            if (wr_en && (write_addr == rt_f)) begin
                rt_rd = write_data;
            end
`endif
        end
    end

    // Logical immediates (andi/ori/xori) zero-extend, lui shifts into the upper
    // half, everything else is arithmetic and sign-extends.
    always_comb begin
        ext_imm = '0;
        case (op_f)
            6'h0C, 6'h0D, 6'h0E: ext_imm = DATA_W'(imm_f);
            6'h0F:               ext_imm = DATA_W'({imm_f, 16'h0000});
            default:             ext_imm = DATA_W'($signed(imm_f));
        endcase
    end

    // Load-use check against the instruction now in ID; out_valid qualifies the
    // EX-side information because the load is only real if the bank held one.
    assign hazard_stall = ex_mem_read && out_valid && (ex_rt_addr != 5'd0)
                       && ((ex_rt_addr == rs_f) || (ex_rt_addr == rt_f)) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            rs_data      <= '0;
            rt_data      <= '0;
            rs_addr_out  <= '0;
            rt_addr_out  <= '0;
            rd_addr_out  <= '0;
            opcode       <= '0;
            funct        <= '0;
            extended_imm <= '0;
            pc_out       <= '0;
        end else if (flush || (!stall && !in_valid)) begin
            // flush beats stall; an empty slot also becomes a clean bubble
            out_valid    <= 1'b0;
            rs_data      <= '0;
            rt_data      <= '0;
            rs_addr_out  <= '0;
            rt_addr_out  <= '0;
            rd_addr_out  <= '0;
            opcode       <= '0;
            funct        <= '0;
            extended_imm <= '0;
            pc_out       <= '0;
        end else if (!stall) begin
            out_valid    <= 1'b1;
            rs_data      <= rs_rd;
            rt_data      <= rt_rd;
            rs_addr_out  <= rs_f;
            rt_addr_out  <= rt_f;
            rd_addr_out  <= rd_f;
            opcode       <= op_f;
            funct        <= fn_f;
            extended_imm <= ext_imm;
            pc_out       <= pc_in;
        end
    end

endmodule
